// File: rtl/i2c_slave_core_if.sv
// Pin-side and local-register-side signals of the I2C target core.
interface i2c_slave_core_if;
    logic       scl_i;
    logic       sda_i;
    logic       scl_o;
    logic       scl_dir_o;
    logic       sda_o;
    logic       sda_dir_o;
    logic       busy_o;
    logic       rd_o;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic       tx_req_o;
    logic [7:0] tx_data_i;
    logic       start_o;
    logic       stop_o;

    modport slave (
        input  scl_i, sda_i, tx_data_i,
        output scl_o, scl_dir_o, sda_o, sda_dir_o, busy_o, rd_o,
               rx_valid_o, rx_data_o, tx_req_o, start_o, stop_o
    );

    modport master (
        output scl_i, sda_i, tx_data_i,
        input  scl_o, scl_dir_o, sda_o, sda_dir_o, busy_o, rd_o,
               rx_valid_o, rx_data_o, tx_req_o, start_o, stop_o
    );
endinterface

// File: rtl/i2c_slave_core.sv
// I2C target engine: START/STOP detection, 7-bit address match, byte receive
// with ACK, byte transmit from tx_data_i. Pulls SDA low only, never touches SCL.
module i2c_slave_core #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [6:0]       addr_i,
    i2c_slave_core_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   start_ev, stop_ev, scl_rise, scl_fall;

    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [6:0] own_q, own_d;
    logic       rd_q, rd_d;
    logic       dir_q, dir_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;

    // Pin synchronisers and edge registers; idle-high bus after reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            own_q      <= '0;
            rd_q       <= 1'b0;
            dir_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            own_q      <= own_d;
            rd_q       <= rd_d;
            dir_q      <= dir_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // Next-state and datapath update; disable, then STOP, then START win over SCL edges
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        own_d      = (state_q == IDLE) ? addr_i : own_q;
        rd_d       = rd_q;
        dir_d      = dir_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end else if (stop_ev) begin
            stop_d  = 1'b1;
            state_d = IDLE;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end else if (start_ev) begin
            start_d = 1'b1;
            state_d = ADDR;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == own_q) begin
                            rd_d    = shift_q[0];
                            dir_d   = 1'b1;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rd_q) begin
                            tx_req_d = 1'b1;
                            shift_d  = bus.tx_data_i;
                            dir_d    = ~bus.tx_data_i[7];
                            cnt_d    = 4'd1;
                            state_d  = TX;
                        end else begin
                            dir_d   = 1'b0;
                            state_d = RX;
                        end
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        dir_d      = 1'b1;
                        cnt_d      = '0;
                        state_d    = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        dir_d   = 1'b0;
                        state_d = RX;
                    end
                end
                // shift_q[7] is the bit currently on the bus; cnt_q counts bits presented
                TX: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            dir_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = TX_ACK;
                        end else begin
                            dir_d   = ~shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                // NACK leaves at the sample point; reaching a fall here means ACK
                TX_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall) begin
                        tx_req_d = 1'b1;
                        shift_d  = bus.tx_data_i;
                        dir_d    = ~bus.tx_data_i[7];
                        cnt_d    = 4'd1;
                        state_d  = TX;
                    end
                end
                default: begin
                    dir_d = 1'b0;
                end
            endcase
        end
    end

    // Output drive from registered state
    always_comb begin
        bus.scl_o      = 1'b0;
        bus.scl_dir_o  = 1'b0;
        bus.sda_o      = 1'b0;
        bus.sda_dir_o  = dir_q;
        bus.busy_o     = (state_q == ADDR_ACK) || (state_q == RX) || (state_q == RX_ACK) ||
                         (state_q == TX) || (state_q == TX_ACK);
        bus.rd_o       = rd_q;
        bus.rx_valid_o = rx_valid_q;
        bus.rx_data_o  = rx_data_q;
        bus.tx_req_o   = tx_req_q;
        bus.start_o    = start_q;
        bus.stop_o     = stop_q;
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: behavioural I2C host on an open-drain SDA line,
// directed scenarios followed by randomized transactions against a
// transaction-level expectation (address match -> ACKs and data flow).
module tb_i2c_slave_core;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [6:0] addr = 7'h50;
    logic       scl_host = 1'b1;
    logic       sda_host = 1'b1;

    i2c_slave_core_if bus();

    i2c_slave_core #(.SYNC_STAGES(2)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .addr_i  (addr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.scl_i = scl_host;
    assign bus.sda_i = sda_host & ~bus.sda_dir_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0, n_stop = 0, n_rxv = 0, n_txr = 0;
    logic [7:0] rxq[$];

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.start_o)    n_start++;
        if (bus.stop_o)     n_stop++;
        if (bus.tx_req_o)   n_txr++;
        if (bus.rx_valid_o) begin
            n_rxv++;
            rxq.push_back(bus.rx_data_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qat(input int i);
        return (i < rxq.size()) ? rxq[i] : 8'hxx;
    endfunction

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic h_start();
        sda_host = 1'b1; wt(H);
        scl_host = 1'b1; wt(H);
        sda_host = 1'b0; wt(H);
        scl_host = 1'b0; wt(H);
    endtask

    task automatic h_stop();
        sda_host = 1'b0; wt(H);
        scl_host = 1'b1; wt(H);
        sda_host = 1'b1; wt(H);
    endtask

    task automatic wbit(input logic b);
        sda_host = b;    wt(H);
        scl_host = 1'b1; wt(H);
        scl_host = 1'b0; wt(2);
    endtask

    task automatic rbit(output logic b);
        sda_host = 1'b1; wt(H);
        scl_host = 1'b1; wt(H/2);
        b = bus.sda_i;   wt(H/2);
        scl_host = 1'b0; wt(2);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        acked = ~b;
    endtask

    task automatic rbyte(output logic [7:0] d, input logic host_ack, input logic [7:0] next_tx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        bus.tx_data_i = next_tx;
        wbit(~host_ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        int         s0, p0, r0, t0;
        logic [6:0] own, tgt;
        logic       match, rw;
        int         nb;
        logic [7:0] data[4];
        logic [7:0] exp_rx[$];

        bus.tx_data_i = 8'h00;
        en = 1'b1;
        wt(4);
        chk("rst_outputs", {bus.sda_dir_o, bus.busy_o, bus.rd_o, bus.rx_valid_o, bus.tx_req_o,
                            bus.start_o, bus.stop_o, bus.scl_o, bus.scl_dir_o, bus.sda_o}, '0);
        chk("rst_rx_data", bus.rx_data_o, 8'h00);
        rst_n = 1'b1;
        wt(4);

        // Write 0x12, 0x34 to 0x50
        s0 = n_start; p0 = n_stop; rxq.delete();
        h_start();
        wbyte(8'hA0, ack); chk("wr_addr_ack", ack, 1);
        chk("wr_busy", bus.busy_o, 1);
        wbyte(8'h12, ack); chk("wr_b0_ack", ack, 1);
        wbyte(8'h34, ack); chk("wr_b1_ack", ack, 1);
        h_stop(); wt(4);
        chk("wr_rx_cnt", rxq.size(), 2);
        chk("wr_rx0", qat(0), 8'h12);
        chk("wr_rx1", qat(1), 8'h34);
        chk("wr_starts", n_start - s0, 1);
        chk("wr_stops", n_stop - p0, 1);
        chk("wr_busy_after", bus.busy_o, 0);
        chk("wr_rd", bus.rd_o, 0);

        // Read 0x5A, 0xC3: ACK then NACK
        t0 = n_txr; bus.tx_data_i = 8'h5A;
        h_start();
        wbyte(8'hA1, ack); chk("rd_addr_ack", ack, 1);
        rbyte(b, 1'b1, 8'hC3); chk("rd_b0", b, 8'h5A);
        chk("rd_rd", bus.rd_o, 1);
        rbyte(b, 1'b0, 8'h00); chk("rd_b1", b, 8'hC3);
        wt(4);
        chk("rd_nack_release", bus.sda_dir_o, 0);
        chk("rd_nack_notbusy", bus.busy_o, 0);
        chk("rd_txreq", n_txr - t0, 2);
        h_stop(); wt(4);

        // Wrong address: ignored until STOP
        r0 = n_rxv; t0 = n_txr;
        h_start();
        wbyte(8'hA2, ack); chk("na_addr_ack", ack, 0);
        wbyte(8'h55, ack); chk("na_b0_ack", ack, 0);
        h_stop(); wt(4);
        chk("na_rx", n_rxv - r0, 0);
        chk("na_tx", n_txr - t0, 0);

        // Write then repeated START read
        s0 = n_start; rxq.delete(); bus.tx_data_i = 8'h9E;
        h_start();
        wbyte(8'hA0, ack); chk("rs_waddr_ack", ack, 1);
        wbyte(8'h07, ack); chk("rs_wb_ack", ack, 1);
        chk("rs_rd_before", bus.rd_o, 0);
        h_start();
        wbyte(8'hA1, ack); chk("rs_raddr_ack", ack, 1);
        chk("rs_rd_after", bus.rd_o, 1);
        rbyte(b, 1'b0, 8'h00); chk("rs_rb", b, 8'h9E);
        h_stop(); wt(4);
        chk("rs_starts", n_start - s0, 2);
        chk("rs_rx_cnt", rxq.size(), 1);
        chk("rs_rx0", qat(0), 8'h07);

        // STOP after 4 bits of a write byte
        r0 = n_rxv; p0 = n_stop;
        h_start();
        wbyte(8'hA0, ack); chk("ps_addr_ack", ack, 1);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        h_stop(); wt(4);
        chk("ps_rx", n_rxv - r0, 0);
        chk("ps_stop", n_stop - p0, 1);
        chk("ps_idle", {bus.busy_o, bus.sda_dir_o}, 2'b00);

        // Reset while driving bit7=0 in TX
        bus.tx_data_i = 8'h00;
        h_start();
        wbyte(8'hA1, ack); chk("rt_addr_ack", ack, 1);
        wt(4);
        chk("rt_driving", bus.sda_dir_o, 1);
        rst_n = 1'b0; wt(1);
        chk("rt_released", {bus.sda_dir_o, bus.busy_o, bus.rd_o, bus.rx_valid_o, bus.tx_req_o,
                            bus.start_o, bus.stop_o}, '0);
        chk("rt_rx_data", bus.rx_data_o, 8'h00);
        rst_n = 1'b1; wt(2);
        rxq.delete();
        h_start();
        wbyte(8'hA0, ack); chk("rt_new_addr_ack", ack, 1);
        wbyte(8'h66, ack); chk("rt_new_b_ack", ack, 1);
        h_stop(); wt(4);
        chk("rt_new_rx", qat(0), 8'h66);

        // Disable while driving SDA: released, no pulses while disabled
        bus.tx_data_i = 8'h00;
        h_start();
        wbyte(8'hA1, ack); chk("en_addr_ack", ack, 1);
        wt(4);
        en = 1'b0; wt(1);
        chk("en_release", {bus.sda_dir_o, bus.busy_o}, 2'b00);
        p0 = n_stop; s0 = n_start;
        h_stop(); h_start(); h_stop(); wt(4);
        chk("en_no_pulses", (n_stop - p0) + (n_start - s0), 0);
        en = 1'b1; wt(2);
        chk("tie_offs", {bus.scl_o, bus.scl_dir_o, bus.sda_o}, 3'b000);

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            own   = 7'($urandom_range(0, 127));
            match = 1'($urandom_range(0, 1));
            tgt   = match ? own : (own ^ 7'($urandom_range(1, 127)));
            rw    = 1'($urandom_range(0, 1));
            nb    = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) data[k] = 8'($urandom);
            addr = own;
            rxq.delete(); exp_rx.delete();
            t0 = n_txr;
            bus.tx_data_i = data[0];
            wt(2);
            h_start();
            wbyte({tgt, rw}, ack); chk("rnd_addr_ack", ack, match);
            for (int k = 0; k < nb; k++) begin
                if (rw) begin
                    rbyte(b, k < nb - 1, data[k + 1]);
                    chk("rnd_rd_byte", b, match ? data[k] : 8'hFF);
                end else begin
                    wbyte(data[k], ack);
                    chk("rnd_wr_ack", ack, match);
                    if (match) exp_rx.push_back(data[k]);
                end
            end
            h_stop(); wt(4);
            chk("rnd_rx_cnt", rxq.size(), exp_rx.size());
            for (int k = 0; k < exp_rx.size(); k++) chk("rnd_rx_byte", qat(k), exp_rx[k]);
            chk("rnd_txreq", n_txr - t0, (match && rw) ? nb : 0);
            chk("rnd_idle", {bus.busy_o, bus.sda_dir_o}, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
